// File: rtl/sm_board_input_pkg.sv
// sm_board_input_pkg
// Shared constants for the board input conditioner:
//   - CLK_HZ and the default debounce / auto-repeat constants derived from it
//   - inactive (reset) pin values for buttons and switches
//   - cnt_width(): counter width helper that never returns 0
// Optional feature macro used by sm_board_input: SM_BOARD_INPUT_AUTOREPEAT_EN
package sm_board_input_pkg;

    localparam int unsigned CLK_HZ              = 50_000_000;
    // 10 ms debounce window
    localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
    // 500 ms to first repeat, then 100 ms between repeats
    localparam int unsigned DEF_REPEAT_DELAY    = CLK_HZ / 2;
    localparam int unsigned DEF_REPEAT_PERIOD   = CLK_HZ / 10;

    // Pin levels while nothing is touched: buttons pulled high, switches low.
    localparam logic KEY_PIN_INACTIVE = 1'b1;
    localparam logic SW_PIN_INACTIVE  = 1'b0;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sm_debounce.sv
// sm_debounce
// One input channel: 2-FF synchroniser -> debounce counter -> stable register
// -> registered rise/fall pulses.
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing synced cycles needed to accept (>= 2)
//   INVERT           1 for active-low pins; inversion is applied after the synchroniser
//   PIN_INACTIVE     pin value the synchroniser resets to
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   pin_raw      asynchronous pin
//   level        debounced, active-high level
//   rise / fall  1-cycle pulses on accepted 0->1 / 1->0, aligned with level
//   fall_next    combinational: a fall is accepted on the coming edge
module sm_debounce
    import sm_board_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          INVERT          = 1'b0,
    parameter logic        PIN_INACTIVE    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic fall_next
);

    localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          synced;

    assign synced = sync2_q ^ INVERT;

    always_comb begin
        sync1_d   = pin_raw;
        sync2_d   = sync1_q;
        stable_d  = stable_q;
        cnt_d     = '0;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        fall_next = 1'b0;
        // Any cycle where synced matches stable clears the count: a glitch
        // earns no partial credit towards the next acceptance.
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d  = synced;
                rise_d    = synced;
                fall_d    = ~synced;
                fall_next = ~synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= PIN_INACTIVE;
            sync2_q  <= PIN_INACTIVE;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/sm_board_input.sv
// sm_board_input
// Board input conditioner: debounced levels and 1-cycle edge pulses for the
// active-low push-buttons and active-high slide switches.
// Optional feature macro: SM_BOARD_INPUT_AUTOREPEAT_EN (per-key auto-repeat of
// key_press while a key is held; switches unaffected).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   key_n_raw      raw buttons, 0 = pressed
//   sw_raw         raw switches
//   key_level      debounced buttons, 1 = pressed
//   key_press      pulse on accepted press (plus repeats when enabled)
//   key_release    pulse on accepted release
//   sw_level       debounced switches
//   sw_change      pulse on any accepted switch transition
module sm_board_input
    import sm_board_input_pkg::*;
#(
    parameter int unsigned KEY_W           = 4,
    parameter int unsigned SW_W            = 10,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_W-1:0]  key_n_raw,
    input  logic [SW_W-1:0]   sw_raw,
    output logic [KEY_W-1:0]  key_level,
    output logic [KEY_W-1:0]  key_press,
    output logic [KEY_W-1:0]  key_release,
    output logic [SW_W-1:0]   sw_level,
    output logic [SW_W-1:0]   sw_change
);

    localparam int unsigned N = KEY_W + SW_W;

    // Channels 0..KEY_W-1 are keys, the rest are switches.
    logic [N-1:0] ch_raw;
    logic [N-1:0] ch_level;
    logic [N-1:0] ch_rise;
    logic [N-1:0] ch_fall;
    logic [N-1:0] ch_fall_next;

    assign ch_raw = {sw_raw, key_n_raw};

    for (genvar i = 0; i < N; i++) begin : g_ch
        if (i < KEY_W) begin : g_key
            sm_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .INVERT          (1'b1),
                .PIN_INACTIVE    (KEY_PIN_INACTIVE)
            ) u_deb (
                .clk       (clk),
                .rst_n     (rst_n),
                .pin_raw   (ch_raw[i]),
                .level     (ch_level[i]),
                .rise      (ch_rise[i]),
                .fall      (ch_fall[i]),
                .fall_next (ch_fall_next[i])
            );
        end else begin : g_sw
            sm_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .INVERT          (1'b0),
                .PIN_INACTIVE    (SW_PIN_INACTIVE)
            ) u_deb (
                .clk       (clk),
                .rst_n     (rst_n),
                .pin_raw   (ch_raw[i]),
                .level     (ch_level[i]),
                .rise      (ch_rise[i]),
                .fall      (ch_fall[i]),
                .fall_next (ch_fall_next[i])
            );
        end
    end

    assign key_level   = ch_level[KEY_W-1:0];
    assign key_release = ch_fall[KEY_W-1:0];
    assign sw_level    = ch_level[N-1:KEY_W];
    assign sw_change   = ch_rise[N-1:KEY_W] | ch_fall[N-1:KEY_W];

`ifdef SM_BOARD_INPUT_AUTOREPEAT_EN
    // Repeat counter per key. It counts edges since the accepted press
    // (first interval, REPEAT_DELAY) or since the last repeat (REPEAT_PERIOD).
    // REPEAT_DELAY and REPEAT_PERIOD are expected to be >= 2.
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = cnt_width(RMAX + 1);
    localparam logic [RW-1:0] REP_FIRST_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT_LAST  = RW'(REPEAT_PERIOD - 1);

    logic [KEY_W-1:0][RW-1:0] rep_cnt_q, rep_cnt_d;
    logic [KEY_W-1:0]         rep_first_q, rep_first_d;
    logic [KEY_W-1:0]         rep_pulse_q, rep_pulse_d;
    logic                     unused_sw_fall_next;

    always_comb begin
        for (int k = 0; k < int'(KEY_W); k++) begin
            rep_cnt_d[k]   = '0;
            rep_first_d[k] = 1'b0;
            rep_pulse_d[k] = 1'b0;
            // A release accepted on this edge suppresses a repeat due on the
            // same edge (fall_next looks one edge ahead of key_level).
            if (ch_level[k] && !ch_fall_next[k]) begin
                if (ch_rise[k]) begin
                    // First edge after the press pulse edge.
                    rep_cnt_d[k]   = RW'(1);
                    rep_first_d[k] = 1'b1;
                end else if (rep_cnt_q[k] == (rep_first_q[k] ? REP_FIRST_LAST : REP_NEXT_LAST)) begin
                    rep_pulse_d[k] = 1'b1;
                    rep_first_d[k] = 1'b0;
                end else begin
                    rep_cnt_d[k]   = rep_cnt_q[k] + 1'b1;
                    rep_first_d[k] = rep_first_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_first_q <= '0;
            rep_pulse_q <= '0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            rep_pulse_q <= rep_pulse_d;
        end
    end

    assign key_press           = ch_rise[KEY_W-1:0] | rep_pulse_q;
    assign unused_sw_fall_next = ^ch_fall_next[N-1:KEY_W];
`else
    logic unused_repeat;

    assign key_press     = ch_rise[KEY_W-1:0];
    assign unused_repeat = ^{ch_fall_next, REPEAT_DELAY, REPEAT_PERIOD};
`endif

endmodule

// File: tb/tb_sm_board_input.sv
// tb_sm_board_input
// Directed bench for sm_board_input with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. A table of {pins, wait, expected outputs, expected pulse
// counts} records drives the single-clock scenarios; hand-written sequences
// cover reset-time switches, reset mid-debounce and auto-repeat.
module tb_sm_board_input;

    localparam int KEY_W = 4;
    localparam int SW_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [KEY_W-1:0]  key_n_raw = 4'hF;
    logic [SW_W-1:0]   sw_raw = '0;
    logic [KEY_W-1:0]  key_level, key_press, key_release;
    logic [SW_W-1:0]   sw_level, sw_change;

    sm_board_input #(
        .KEY_W           (KEY_W),
        .SW_W            (SW_W),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n_raw   (key_n_raw),
        .sw_raw      (sw_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .sw_level    (sw_level),
        .sw_change   (sw_change)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int failures = 0;
    int n_press = 0;
    int n_rel = 0;
    int n_chg = 0;

    // One clock edge; sample #1 later and accumulate pulse counts.
    task automatic tick();
        @(posedge clk);
        #1;
        n_press += $countones(key_press);
        n_rel   += $countones(key_release);
        n_chg   += $countones(sw_change);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] key_n;
        logic [9:0] sw;
        int         n_wait;
        logic [3:0] e_kl;
        logic [3:0] e_kp;
        logic [3:0] e_kr;
        logic [9:0] e_sl;
        logic [9:0] e_sc;
        int         e_np;
        int         e_nr;
        int         e_nc;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int exp_np;
        logic exp_p;

        //             key_n  sw      wait kl    kp    kr    sl       sc       np nr nc
        vecs[0]  = '{4'hF, 10'h000, 50, 4'h0, 4'h0, 4'h0, 10'h000, 10'h000, 0, 0, 0};
        vecs[1]  = '{4'hD, 10'h000, 5,  4'h0, 4'h0, 4'h0, 10'h000, 10'h000, 0, 0, 0};
        vecs[2]  = '{4'hD, 10'h000, 1,  4'h2, 4'h2, 4'h0, 10'h000, 10'h000, 1, 0, 0};
        vecs[3]  = '{4'hD, 10'h000, 2,  4'h2, 4'h0, 4'h0, 10'h000, 10'h000, 0, 0, 0};
        vecs[4]  = '{4'hF, 10'h000, 5,  4'h2, 4'h0, 4'h0, 10'h000, 10'h000, 0, 0, 0};
        vecs[5]  = '{4'hF, 10'h000, 1,  4'h0, 4'h0, 4'h2, 10'h000, 10'h000, 0, 1, 0};
        vecs[6]  = '{4'hF, 10'h000, 3,  4'h0, 4'h0, 4'h0, 10'h000, 10'h000, 0, 0, 0};
        // key 0 bounce: low 3, high 1, low 3, high
        vecs[7]  = '{4'hE, 10'h000, 3,  4'h0, 4'h0, 4'h0, 10'h000, 10'h000, 0, 0, 0};
        vecs[8]  = '{4'hF, 10'h000, 1,  4'h0, 4'h0, 4'h0, 10'h000, 10'h000, 0, 0, 0};
        vecs[9]  = '{4'hE, 10'h000, 3,  4'h0, 4'h0, 4'h0, 10'h000, 10'h000, 0, 0, 0};
        vecs[10] = '{4'hF, 10'h000, 10, 4'h0, 4'h0, 4'h0, 10'h000, 10'h000, 0, 0, 0};
        // switch rise and fall
        vecs[11] = '{4'hF, 10'h155, 6,  4'h0, 4'h0, 4'h0, 10'h155, 10'h155, 0, 0, 5};
        vecs[12] = '{4'hF, 10'h155, 1,  4'h0, 4'h0, 4'h0, 10'h155, 10'h000, 0, 0, 0};
        vecs[13] = '{4'hF, 10'h000, 6,  4'h0, 4'h0, 4'h0, 10'h000, 10'h155, 0, 0, 5};
        // simultaneous key 2 and switch 9
        vecs[14] = '{4'hB, 10'h200, 6,  4'h4, 4'h4, 4'h0, 10'h200, 10'h200, 1, 0, 1};
        vecs[15] = '{4'hF, 10'h000, 6,  4'h0, 4'h0, 4'h4, 10'h000, 10'h200, 0, 1, 1};

        // reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_key_level", 32'(key_level), 32'h0);
        check("reset_key_press", 32'(key_press), 32'h0);
        check("reset_sw_level", 32'(sw_level), 32'h0);
        check("reset_sw_change", 32'(sw_change), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // table-driven vectors
        for (int v = 0; v < 16; v++) begin
            key_n_raw = vecs[v].key_n;
            sw_raw    = vecs[v].sw;
            n_press = 0; n_rel = 0; n_chg = 0;
            repeat (vecs[v].n_wait) tick();
            check($sformatf("v%0d_key_level", v),   32'(key_level),   32'(vecs[v].e_kl));
            check($sformatf("v%0d_key_press", v),   32'(key_press),   32'(vecs[v].e_kp));
            check($sformatf("v%0d_key_release", v), 32'(key_release), 32'(vecs[v].e_kr));
            check($sformatf("v%0d_sw_level", v),    32'(sw_level),    32'(vecs[v].e_sl));
            check($sformatf("v%0d_sw_change", v),   32'(sw_change),   32'(vecs[v].e_sc));
            check($sformatf("v%0d_n_press", v),     32'(n_press),     32'(vecs[v].e_np));
            check($sformatf("v%0d_n_release", v),   32'(n_rel),       32'(vecs[v].e_nr));
            check($sformatf("v%0d_n_change", v),    32'(n_chg),       32'(vecs[v].e_nc));
        end

        // switches on while reset is released
        rst_n = 1'b0;
        sw_raw = 10'h3FF;
        tick();
        tick();
        rst_n = 1'b1;
        n_chg = 0;
        repeat (5) tick();
        check("swrst_level_early", 32'(sw_level), 32'h0);
        tick();
        check("swrst_level", 32'(sw_level), 32'h3FF);
        check("swrst_change", 32'(sw_change), 32'h3FF);
        tick();
        check("swrst_change_gone", 32'(sw_change), 32'h0);
        check("swrst_n_change", 32'(n_chg), 32'd10);
        sw_raw = 10'h000;
        repeat (8) tick();
        check("swrst_level_off", 32'(sw_level), 32'h0);

        // reset two cycles into a key debounce
        sw_raw = 10'h001;
        repeat (8) tick();
        check("midrst_sw_before", 32'(sw_level), 32'h1);
        key_n_raw = 4'hE;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_key_level", 32'(key_level), 32'h0);
        check("midrst_key_press", 32'(key_press), 32'h0);
        check("midrst_sw_level", 32'(sw_level), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        n_press = 0; n_chg = 0;
        repeat (5) tick();
        check("midrst_key_early", 32'(key_level), 32'h0);
        tick();
        check("midrst_key_level_after", 32'(key_level), 32'h1);
        check("midrst_key_press_after", 32'(key_press), 32'h1);
        check("midrst_sw_level_after", 32'(sw_level), 32'h1);
        check("midrst_sw_change_after", 32'(sw_change), 32'h1);

        // held key: repeat pulses (offset from press pulse), then a release
        // that lands on the same edge as a due repeat
        for (int off = 1; off <= 31; off++) begin
            tick();
`ifdef SM_BOARD_INPUT_AUTOREPEAT_EN
            exp_p = (off >= 10) && ((off - 10) % 3 == 0);
`else
            exp_p = 1'b0;
`endif
            check($sformatf("rep_press_off%0d", off), 32'(key_press), 32'(exp_p));
        end
        key_n_raw = 4'hF;
        for (int off = 32; off <= 40; off++) begin
            tick();
`ifdef SM_BOARD_INPUT_AUTOREPEAT_EN
            exp_p = (off == 34);
`else
            exp_p = 1'b0;
`endif
            check($sformatf("rel_press_off%0d", off), 32'(key_press), 32'(exp_p));
            check($sformatf("rel_release_off%0d", off), 32'(key_release), 32'(off == 37));
        end
`ifdef SM_BOARD_INPUT_AUTOREPEAT_EN
        exp_np = 10;
`else
        exp_np = 1;
`endif
        check("rep_total_press", 32'(n_press), 32'(exp_np));
        check("rep_key_level_end", 32'(key_level), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
